// File: rtl/shift_seq_if.sv
// Handshake and serial-link bundle for shift_seq_ctrl.
// The master side is the producer/consumer; the slave side is the sequencer.
interface shift_seq_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         sin;
    logic         sout;
    logic         shift_en;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;

    modport master (
        output in_valid, in_data, sin, out_ready,
        input  in_ready, sout, shift_en, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, sin, out_ready,
        output in_ready, sout, shift_en, out_valid, out_data, busy
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Serialiser/deserialiser sequencer: loads a parallel word, shifts it out over W cycles
// while capturing W serial bits, then presents the captured word on a valid/ready port.
module shift_seq_ctrl #(
    parameter int W         = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    shift_seq_if.slave  bus
);
    localparam int            CW       = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  sreg, sreg_nxt;
    logic [W-1:0]  oreg, oreg_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [W-1:0]  shifted;
    logic          end_bit;
    logic          accept;

    // Shift direction is fixed at elaboration; sin always enters at the end opposite sout.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign shifted = {bus.sin, sreg[W-1:1]};
            assign end_bit = sreg[0];
        end else begin : g_msb_first
            assign shifted = {sreg[W-2:0], bus.sin};
            assign end_bit = sreg[W-1];
        end
    endgenerate

    // In HOLD, taking the new word while the old one is consumed avoids an IDLE bubble.
    assign bus.in_ready = rst_n && ((state == IDLE) || ((state == HOLD) && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;

    // NOTE: every variable gets a default before the case, so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        oreg_nxt  = oreg;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    sreg_nxt  = bus.in_data;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                sreg_nxt = shifted;
                if (cnt == CNT_LAST) begin
                    oreg_nxt  = shifted;
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    if (accept) begin
                        sreg_nxt  = bus.in_data;
                        cnt_nxt   = '0;
                        state_nxt = SHIFT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            oreg  <= '0;
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
            oreg  <= oreg_nxt;
        end
    end

    // Outputs decode straight from registers, so they are glitch-free of the inputs.
    assign bus.shift_en  = (state == SHIFT);
    assign bus.sout      = (state == SHIFT) && end_bit;
    assign bus.out_valid = (state == HOLD);
    assign bus.busy      = (state != IDLE);
    assign bus.out_data  = oreg;

    a_hold_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state == HOLD && !bus.out_ready) |=> (state == HOLD && $stable(oreg))
    );

    a_cnt_bound: assert property (
        @(posedge clk) disable iff (!rst_n) (cnt <= CNT_LAST)
    );
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: one MSB-first and one LSB-first instance, W=8.
module tb_shift_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    shift_seq_if #(.W(8)) m ();
    shift_seq_if #(.W(8)) l ();

    logic loop_m = 1'b0, sin_m = 1'b0;
    logic loop_l = 1'b0, sin_l = 1'b0;
    assign m.sin = loop_m ? m.sout : sin_m;
    assign l.sin = loop_l ? l.sout : sin_l;

    shift_seq_ctrl #(.W(8), .LSB_FIRST(1'b0)) dut_m (.clk(clk), .rst_n(rst_n), .bus(m));
    shift_seq_ctrl #(.W(8), .LSB_FIRST(1'b1)) dut_l (.clk(clk), .rst_n(rst_n), .bus(l));

    logic       bits_m[$];
    logic       bits_l[$];
    logic [7:0] words_m[$];
    logic [7:0] words_l[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop expected sout bits on shift cycles and expected words on handoff.
    always @(negedge clk) begin
        if (m.shift_en) begin
            if (bits_m.size() == 0) begin
                total++; bad++;
                $display("FAIL sout_m_unexpected: got shift cycle with sout=%0b, expected none", m.sout);
            end else check("sout_m", m.sout, bits_m.pop_front());
        end
        if (m.out_valid && m.out_ready) begin
            if (words_m.size() == 0) begin
                total++; bad++;
                $display("FAIL word_m_unexpected: got %0h, expected none", m.out_data);
            end else check("out_data_m", m.out_data, words_m.pop_front());
        end
    end

    always @(negedge clk) begin
        if (l.shift_en) begin
            if (bits_l.size() == 0) begin
                total++; bad++;
                $display("FAIL sout_l_unexpected: got shift cycle with sout=%0b, expected none", l.sout);
            end else check("sout_l", l.sout, bits_l.pop_front());
        end
        if (l.out_valid && l.out_ready) begin
            if (words_l.size() == 0) begin
                total++; bad++;
                $display("FAIL word_l_unexpected: got %0h, expected none", l.out_data);
            end else check("out_data_l", l.out_data, words_l.pop_front());
        end
    end

    function automatic logic rdy(input int sel);
        return (sel == 0) ? m.in_ready : l.in_ready;
    endfunction

    function automatic logic vld(input int sel);
        return (sel == 0) ? m.out_valid : l.out_valid;
    endfunction

    function automatic logic shf(input int sel);
        return (sel == 0) ? m.shift_en : l.shift_en;
    endfunction

    task automatic drive_in(input int sel, input logic v, input logic [7:0] d);
        if (sel == 0) begin m.in_valid = v; m.in_data = d; end
        else begin l.in_valid = v; l.in_data = d; end
    endtask

    // Expected sout sequence for a word, given the shift direction.
    task automatic push_bits(input int sel, input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            if (sel == 0) bits_m.push_back(w[7 - i]);
            else bits_l.push_back(w[i]);
        end
    endtask

    // Called just after a posedge; returns just after the accept edge.
    task automatic send(input int sel, input logic [7:0] d);
        int n;
        drive_in(sel, 1'b1, d);
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (rdy(sel)) break;
        end
        check("accept_timeout", (n < 50), 1);
        @(posedge clk); #1;
        drive_in(sel, 1'b0, 8'h00);
    endtask

    task automatic wait_valid(input int sel, output int edges, output int shifts);
        edges = 0;
        shifts = 0;
        while (!vld(sel) && edges < 40) begin
            if (shf(sel)) shifts++;
            @(posedge clk); #1;
            edges++;
        end
        check("valid_timeout", vld(sel), 1);
    endtask

    initial begin
        int edges, shifts;
        drive_in(0, 1'b0, 8'h00);
        drive_in(1, 1'b0, 8'h00);
        m.out_ready = 1'b0;
        l.out_ready = 1'b0;

        // Power-on reset.
        #1;
        check("rst_in_ready", m.in_ready, 0);
        check("rst_out_valid", m.out_valid, 0);
        check("rst_out_data", m.out_data, 8'h00);
        check("rst_busy", m.busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", m.in_ready, 1);
        check("idle_busy", m.busy, 0);

        // T1: reset during shift cycle 3 aborts the word.
        bits_m.push_back(1'b1);
        bits_m.push_back(1'b0);
        send(0, 8'hA5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t1_in_shift", m.shift_en, 1);
        rst_n = 1'b0;
        #1;
        check("t1_sout", m.sout, 0);
        check("t1_shift_en", m.shift_en, 0);
        check("t1_out_valid", m.out_valid, 0);
        check("t1_busy", m.busy, 0);
        check("t1_out_data", m.out_data, 8'h00);
        check("t1_in_ready", m.in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t1_post_in_ready", m.in_ready, 1);
        check("t1_post_out_valid", m.out_valid, 0);
        check("t1_bits_drained", bits_m.size(), 0);

        // T2: loopback returns the loaded word.
        loop_m = 1'b1;
        m.out_ready = 1'b1;
        push_bits(0, 8'hA5);
        words_m.push_back(8'hA5);
        send(0, 8'hA5);
        wait_valid(0, edges, shifts);
        check("t2_latency", edges, 8);
        @(posedge clk); #1;
        check("t2_back_idle", m.busy, 0);
        check("t2_valid_drop", m.out_valid, 0);
        check("t2_data_kept", m.out_data, 8'hA5);

        // T3: fill with ones from an all-zero word.
        loop_m = 1'b0;
        sin_m = 1'b1;
        push_bits(0, 8'h00);
        words_m.push_back(8'hFF);
        send(0, 8'h00);
        wait_valid(0, edges, shifts);
        check("t3_latency", edges, 8);
        check("t3_shift_cycles", shifts, 8);
        check("t3_hold_no_shift", m.shift_en, 0);
        @(posedge clk); #1;

        // T4: backpressure in HOLD with a pending new word.
        loop_m = 1'b1;
        m.out_ready = 1'b0;
        push_bits(0, 8'h5A);
        words_m.push_back(8'h5A);
        send(0, 8'h5A);
        wait_valid(0, edges, shifts);
        drive_in(0, 1'b1, 8'h3C);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_out_valid", m.out_valid, 1);
            check("t4_out_data", m.out_data, 8'h5A);
            check("t4_in_ready", m.in_ready, 0);
            check("t4_no_shift", m.shift_en, 0);
        end

        // T5: handoff and accept in the same cycle.
        push_bits(0, 8'h3C);
        words_m.push_back(8'h3C);
        @(posedge clk); #1;
        m.out_ready = 1'b1;
        @(negedge clk);
        check("t5_in_ready", m.in_ready, 1);
        @(posedge clk); #1;
        drive_in(0, 1'b0, 8'h00);
        check("t5_no_bubble", m.shift_en, 1);
        check("t5_valid_drop", m.out_valid, 0);
        wait_valid(0, edges, shifts);
        check("t5_latency", edges, 8);
        check("t5_shift_cycles", shifts, 8);
        @(posedge clk); #1;

        // T6: LSB-first instance.
        l.out_ready = 1'b1;
        push_bits(1, 8'h01);
        words_l.push_back(8'h00);
        send(1, 8'h01);
        wait_valid(1, edges, shifts);
        check("t6_latency", edges, 8);
        @(posedge clk); #1;
        loop_l = 1'b1;
        push_bits(1, 8'h96);
        words_l.push_back(8'h96);
        send(1, 8'h96);
        wait_valid(1, edges, shifts);
        check("t6_loop_shifts", shifts, 8);
        @(posedge clk); #1;
        check("t6_data_kept", l.out_data, 8'h96);

        repeat (2) @(posedge clk);
        check("bits_m_left", bits_m.size(), 0);
        check("words_m_left", words_m.size(), 0);
        check("bits_l_left", bits_l.size(), 0);
        check("words_l_left", words_l.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
